gcd_operand_queue: RTL and testbench
====================================

# gcd_operand_queue

Operand-pair buffer that sits directly upstream of the GCD top level. It accepts (A, B) pairs from a producer over a valid/ready handshake and stores them in a circular FIFO. It presents one pair at a time on `In_A`/`In_B` with `In_ready` held high until the GCD controller acknowledges the load. This decouples operand producers from the multi-cycle GCD computation.

## Interface
- `numOfBits`, 5: width of each operand; matches the GCD datapath width.
- `depth`, 4: FIFO entries; must be a power of two ≥ 2.
- `Clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Wr_A`  in  numOfBits  producer operand A.
- `Wr_B`  in  numOfBits  producer operand B.
- `Wr_valid`  in  1  producer has a pair on `Wr_A`/`Wr_B`.
- `Wr_ready`  out  1  queue can accept; transfer occurs on an edge where `Wr_valid && Wr_ready`.
- `In_A`  out  numOfBits  presented operand A, to GCD `In_A`.
- `In_B`  out  numOfBits  presented operand B, to GCD `In_B`.
- `In_ready`  out  1  presented pair valid, to GCD `In_ready`.
- `Load_ack`  in  1  GCD controller captured the presented pair.
- `Count`  out  log2(depth)+1  FIFO occupancy, excluding the presented pair.
- `Drop_cnt`  out  8  number of pairs discarded by the zero filter.

## Operation
- Storage is a `depth`-entry circular buffer with write pointer, read pointer and occupancy counter. Pointers wrap modulo `depth`.
- `Wr_ready = (Count != depth)`, decoded from registered `Count`; it has no combinational path from `Wr_valid`.
- Output FSM has two states:
  - IDLE: `In_ready`=0. If `Count != 0`, pop the head into the `In_A`/`In_B` registers, set `In_ready`=1 and go to PRESENT.
  - PRESENT: `In_A`/`In_B`/`In_ready` hold stable. When `Load_ack`=1, clear `In_ready` and go to IDLE.
- `Load_ack` is ignored in IDLE.
- Push and pop on the same edge leave `Count` unchanged, and both pointers advance.
- The presented pair occupies the output register, not a FIFO slot. Total buffered capacity is therefore `depth`+1.
- Operands pass through unmodified; no arithmetic is performed on data.
- `Drop_cnt` increments by 1 per dropped pair and saturates at 255.

## Timing
- Reset values: `In_ready`=0, `In_A`=0, `In_B`=0, `Count`=0, `Drop_cnt`=0, `Wr_ready`=1, both pointers 0, FSM=IDLE.
- Reset mid-operation discards all stored and presented pairs on that edge.
- Latency: a pair written at edge t into an empty queue with the FSM in IDLE appears with `In_ready`=1 after edge t+1.
- Throughput: at most one pair presented every 2 cycles. Ack at edge t gives IDLE after t; next pair presented after t+1.
- When full (`Count`=depth), `Wr_ready`=0. A pop at edge t makes `Wr_ready`=1 after edge t; there is no same-cycle bypass.
- When empty in IDLE, `In_ready` stays 0 and the output registers hold their last values.

## Configuration
- `GCD_ZERO_DROP_EN` defined: a handshaked pair with `Wr_A`=0 and `Wr_B`=0 is accepted but not stored. The write pointer and `Count` are unchanged and `Drop_cnt` increments. This keeps GCD(0,0) away from the datapath.
- `GCD_ZERO_DROP_EN` undefined: all pairs are stored and `Drop_cnt` is tied to 0.

## Test plan
- Reset, then write (12,18) -> one cycle later `In_ready`=1, `In_A`=12, `In_B`=18, `Count`=0. Hold `Load_ack`=0 for 10 cycles -> outputs stay stable.
- Write 5 pairs back-to-back with no ack -> `Count` reaches 4 and `Wr_ready`=0 after the 5th accept (one presented, 4 queued). A 6th `Wr_valid` is not accepted.
- With the queue full, pulse `Load_ack` -> `In_ready` falls, the next pair is presented 1 cycle later and `Wr_ready`=1. Sequence order is preserved across pointer wrap over 12 pairs.
- Write and ack on the same edge with `Count`=2 -> `Count` remains 2, and data order is intact.
- With `GCD_ZERO_DROP_EN` defined, write (0,0), (0,7), (0,0) -> only (0,7) is presented and `Drop_cnt`=2. Without the macro, (0,0) is presented first and `Drop_cnt`=0.
- Assert `rst` while in PRESENT with `Count`=3 -> the next cycle has `In_ready`=0, `Count`=0 and `Wr_ready`=1, and no stale pair is ever presented.

Source files
------------

// File: rtl/gcd_operand_queue_if.sv
// gcd_operand_queue_if: producer write channel and GCD presentation channel of the operand queue
interface gcd_operand_queue_if #(parameter int numOfBits = 5, parameter int depth = 4);
  logic [numOfBits-1:0] Wr_A, Wr_B, In_A, In_B;
  logic Wr_valid, Wr_ready, In_ready, Load_ack;
  logic [$clog2(depth):0] Count;
  logic [7:0] Drop_cnt;
  modport slave (input Wr_A, Wr_B, Wr_valid, Load_ack, output Wr_ready, In_A, In_B, In_ready, Count, Drop_cnt);
  modport master (output Wr_A, Wr_B, Wr_valid, Load_ack, input Wr_ready, In_A, In_B, In_ready, Count, Drop_cnt);
endinterface

// File: rtl/gcd_operand_queue.sv
// gcd_operand_queue: circular FIFO of (A,B) pairs presented one at a time to the GCD core; GCD_ZERO_DROP_EN discards (0,0) pairs
module gcd_operand_queue #(parameter int numOfBits = 5, parameter int depth = 4) (
  input logic Clk,
  input logic rst,
  gcd_operand_queue_if.slave q
);
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t st_q, st_d;
  logic [2*numOfBits-1:0] mem_q [depth];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [numOfBits-1:0] a_q, b_q;
  logic wr_rdy, acc, zero, push, pop;
  assign wr_rdy = cnt_q != CW'(depth);
  assign q.Wr_ready = wr_rdy;
  assign q.In_A = a_q;
  assign q.In_B = b_q;
  assign q.In_ready = st_q == PRESENT;
  assign q.Count = cnt_q;
  // handshake decode, pop decision and next state; the presented pair lives outside the FIFO
  always_comb begin
    zero = 1'b0;
`ifdef GCD_ZERO_DROP_EN
    zero = q.Wr_A == '0 && q.Wr_B == '0;
`endif
    acc = q.Wr_valid && wr_rdy;
    push = acc && !zero;
    pop = st_q == IDLE && cnt_q != '0;
    st_d = pop ? PRESENT : (st_q == PRESENT && q.Load_ack) ? IDLE : st_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // state, pointers, occupancy, storage and output registers
  always_ff @(posedge Clk) begin
    if (rst) begin
      st_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wp_q] <= {q.Wr_A, q.Wr_B};
        wp_q <= wp_q + 1'b1;
      end
      if (pop) begin
        {a_q, b_q} <= mem_q[rp_q];
        rp_q <= rp_q + 1'b1;
      end
    end
  end
`ifdef GCD_ZERO_DROP_EN
  logic [7:0] drop_q;
  // saturating count of accepted-but-discarded (0,0) pairs
  always_ff @(posedge Clk) begin
    if (rst) drop_q <= '0;
    else if (acc && zero && drop_q != 8'hff) drop_q <= drop_q + 1'b1;
  end
  assign q.Drop_cnt = drop_q;
`else
  assign q.Drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_gcd_operand_queue.sv
// tb_gcd_operand_queue: directed scoreboard bench; expected pairs queued at write, checked as each pair is presented
module tb_gcd_operand_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  logic [9:0] exp_q [$];
  logic prev_rdy = 1'b0;
  gcd_operand_queue_if #(.numOfBits(5), .depth(4)) ifc ();
  gcd_operand_queue #(.numOfBits(5), .depth(4)) dut (.Clk(clk), .rst(rst), .q(ifc));
  always #5 clk = ~clk;
  // monitor: each rising In_ready must present the oldest outstanding expected pair
  always @(negedge clk) begin
    if (ifc.In_ready === 1'b1 && !prev_rdy) begin
      total++;
      if (exp_q.size() == 0)
        $display("FAIL present: got (%0d,%0d) but no pair outstanding", ifc.In_A, ifc.In_B);
      else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({ifc.In_A, ifc.In_B} == e) passed++;
        else $display("FAIL present: got (%0d,%0d) expected (%0d,%0d)", ifc.In_A, ifc.In_B, e[9:5], e[4:0]);
      end
    end
    prev_rdy = ifc.In_ready === 1'b1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  function automatic bit kept(input logic [4:0] a, input logic [4:0] b);
`ifdef GCD_ZERO_DROP_EN
    return !(a == 0 && b == 0);
`else
    return 1'b1;
`endif
  endfunction
  task automatic wr(input logic [4:0] a, input logic [4:0] b);
    logic acc;
    ifc.Wr_A = a;
    ifc.Wr_B = b;
    ifc.Wr_valid = 1'b1;
    acc = ifc.Wr_ready;
    tick();
    ifc.Wr_valid = 1'b0;
    if (acc && kept(a, b)) exp_q.push_back({a, b});
  endtask
  task automatic drain(input int n);
    repeat (n) begin
      ifc.Load_ack = ifc.In_ready;
      tick();
    end
    ifc.Load_ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit stable;
    int n;
    ifc.Wr_A = '0;
    ifc.Wr_B = '0;
    ifc.Wr_valid = 1'b0;
    ifc.Load_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_in_ready", ifc.In_ready, 0);
    chk("rst_count", ifc.Count, 0);
    chk("rst_wr_ready", ifc.Wr_ready, 1);
    chk("rst_in_a", ifc.In_A, 0);
    chk("rst_in_b", ifc.In_B, 0);
    chk("rst_drop", ifc.Drop_cnt, 0);
    wr(12, 18);
    chk("lat_count_after_write", ifc.Count, 1);
    chk("lat_in_ready_early", ifc.In_ready, 0);
    tick();
    chk("lat_in_ready", ifc.In_ready, 1);
    chk("lat_in_a", ifc.In_A, 12);
    chk("lat_in_b", ifc.In_B, 18);
    chk("lat_count", ifc.Count, 0);
    stable = 1'b1;
    repeat (10) begin
      tick();
      stable &= ifc.In_ready && ifc.In_A == 12 && ifc.In_B == 18;
    end
    chk("hold_stable", stable, 1);
    ifc.Load_ack = 1'b1;
    tick();
    ifc.Load_ack = 1'b0;
    chk("ack_in_ready", ifc.In_ready, 0);
    for (int i = 0; i < 5; i++) wr(5'(2 * i + 1), 5'(2 * i + 2));
    chk("full_count", ifc.Count, 4);
    chk("full_wr_ready", ifc.Wr_ready, 0);
    wr(11, 12);
    chk("sixth_rejected_count", ifc.Count, 4);
    chk("sixth_rejected_ready", ifc.Wr_ready, 0);
    ifc.Load_ack = 1'b1;
    tick();
    ifc.Load_ack = 1'b0;
    chk("full_ack_in_ready", ifc.In_ready, 0);
    chk("full_ack_wr_ready", ifc.Wr_ready, 0);
    tick();
    chk("full_next_in_ready", ifc.In_ready, 1);
    chk("full_next_count", ifc.Count, 3);
    chk("full_next_wr_ready", ifc.Wr_ready, 1);
    n = 0;
    for (int c = 0; c < 100 && n < 12; c++) begin
      logic acc;
      ifc.Wr_A = 5'(n + 13);
      ifc.Wr_B = 5'(31 - n);
      ifc.Wr_valid = 1'b1;
      ifc.Load_ack = ifc.In_ready;
      acc = ifc.Wr_ready;
      tick();
      if (acc) begin
        exp_q.push_back({5'(n + 13), 5'(31 - n)});
        n++;
      end
    end
    ifc.Wr_valid = 1'b0;
    chk("wrap_written", n, 12);
    drain(60);
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_empty_count", ifc.Count, 0);
    wr(2, 4);
    wr(6, 8);
    wr(10, 12);
    chk("same_pre_count", ifc.Count, 2);
    chk("same_pre_in_ready", ifc.In_ready, 1);
    ifc.Load_ack = 1'b1;
    tick();
    ifc.Load_ack = 1'b0;
    chk("same_idle_count", ifc.Count, 2);
    wr(14, 16);
    chk("same_edge_count", ifc.Count, 2);
    chk("same_edge_in_ready", ifc.In_ready, 1);
    drain(30);
    chk("same_drained", exp_q.size(), 0);
    wr(0, 0);
`ifdef GCD_ZERO_DROP_EN
    chk("zero_count", ifc.Count, 0);
`else
    chk("zero_count", ifc.Count, 1);
`endif
    wr(0, 7);
    wr(0, 0);
`ifdef GCD_ZERO_DROP_EN
    chk("zero_drop_cnt", ifc.Drop_cnt, 2);
`else
    chk("zero_drop_cnt", ifc.Drop_cnt, 0);
`endif
    drain(20);
    chk("zero_drained", exp_q.size(), 0);
    wr(1, 2);
    wr(3, 4);
    wr(5, 6);
    wr(7, 8);
    chk("rst_pre_count", ifc.Count, 3);
    chk("rst_pre_in_ready", ifc.In_ready, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", ifc.In_ready, 0);
    chk("midrst_count", ifc.Count, 0);
    chk("midrst_wr_ready", ifc.Wr_ready, 1);
    chk("midrst_drop", ifc.Drop_cnt, 0);
    repeat (5) tick();
    chk("midrst_no_stale", ifc.In_ready, 0);
    wr(20, 21);
    drain(6);
    chk("post_rst_drained", exp_q.size(), 0);
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
